// File: rtl/freq_mult_param.sv
// freq_mult_param: measures InFreq period in RefClk cycles and synthesises OutFreq at n times that rate
module freq_mult_param #(
  parameter int CNT_W = 16,
  parameter int N_W = 3,
  parameter bit TRACK = 1'b0
) (
  input  logic             RefClk,
  input  logic             rst,
  input  logic             adjust,
  input  logic             InFreq,
  input  logic [N_W-1:0]   n,
  output logic             OutFreq,
  output logic             done,
  output logic             locked,
  output logic             ovf,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] shiftduration
);
  typedef enum logic [2:0] {IDLE, SYNC, MEASURE, DIVIDE, RUN} state_t;
  localparam int SW = $clog2(CNT_W + 1);
  localparam logic [CNT_W-1:0] MAX = '1;
  state_t state, state_n;
  logic s1, s2, s3, rise;
  logic [CNT_W-1:0] cnt, hcnt, quo, q_next, h_new, div_p, pend_p, pend_h;
  logic [N_W:0] rem, dvsr;
  logic [N_W+1:0] rem_sh;
  logic [N_W-1:0] n_cap;
  logic [SW-1:0] step;
  logic div_busy, div_fin, pend_v, counting, cnt_ovf, toggle, quo_bit;
  assign rise = s2 & ~s3;
  assign locked = state == RUN;
  assign dvsr = {n_cap, 1'b0};
  assign rem_sh = {rem, quo[CNT_W-1]};
  assign quo_bit = rem_sh >= {1'b0, dvsr};
  assign q_next = {quo[CNT_W-2:0], quo_bit};
  assign h_new = (q_next == '0) ? CNT_W'(1) : q_next;
  assign div_fin = div_busy && step == SW'(CNT_W - 1);
  assign counting = state == SYNC || state == MEASURE || (TRACK && (state == DIVIDE || state == RUN));
  assign cnt_ovf = counting && !rise && cnt == MAX;
  assign toggle = state == RUN && hcnt == shiftduration;
  always_comb begin
    state_n = state;
    if (adjust) state_n = SYNC;
    else if (cnt_ovf) state_n = IDLE;
    else if (state == SYNC && rise) state_n = MEASURE;
    else if (state == MEASURE && rise) state_n = DIVIDE;
    else if (state == DIVIDE && div_fin) state_n = RUN;
  end
  always_ff @(posedge RefClk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge RefClk) begin
    if (rst) begin
      {s1, s2, s3} <= '0;
      cnt <= '0;
      hcnt <= '0;
      quo <= '0;
      rem <= '0;
      step <= '0;
      div_busy <= 1'b0;
      div_p <= '0;
      pend_p <= '0;
      pend_h <= '0;
      pend_v <= 1'b0;
      n_cap <= '0;
      OutFreq <= 1'b0;
      done <= 1'b0;
      ovf <= 1'b0;
      period <= '0;
      shiftduration <= '0;
    end else begin
      s1 <= InFreq;
      s2 <= s1;
      s3 <= s2;
      done <= 1'b0;
      if (adjust) begin
        n_cap <= (n == '0) ? N_W'(1) : n;
        ovf <= 1'b0;
        cnt <= '0;
        OutFreq <= 1'b0;
        div_busy <= 1'b0;
        pend_v <= 1'b0;
      end else begin
        if (counting) cnt <= rise ? '0 : cnt + 1'b1;
        if (state == MEASURE && rise) period <= cnt + 1'b1;
        if (div_busy) begin
          quo <= q_next;
          rem <= quo_bit ? (N_W + 1)'(rem_sh - {1'b0, dvsr}) : rem_sh[N_W:0];
          step <= step + 1'b1;
        end
        if (rise && (state == MEASURE || (TRACK && state == RUN && !div_busy))) begin
          quo <= cnt + 1'b1;
          div_p <= cnt + 1'b1;
          rem <= '0;
          step <= '0;
          div_busy <= 1'b1;
        end
        if (state == RUN) begin
          hcnt <= toggle ? CNT_W'(1) : hcnt + 1'b1;
          if (toggle) OutFreq <= ~OutFreq;
          // background results only take effect on a toggle so no half-cycle is cut short
          if (toggle && pend_v) begin
            shiftduration <= pend_h;
            period <= pend_p;
            pend_v <= 1'b0;
          end
        end
        if (div_fin) begin
          div_busy <= 1'b0;
          if (state == DIVIDE) begin
            shiftduration <= h_new;
            done <= 1'b1;
            hcnt <= CNT_W'(1);
            OutFreq <= 1'b0;
          end else begin
            pend_h <= h_new;
            pend_p <= div_p;
            pend_v <= 1'b1;
          end
        end
        if (cnt_ovf) begin
          ovf <= 1'b1;
          OutFreq <= 1'b0;
          div_busy <= 1'b0;
          pend_v <= 1'b0;
        end
      end
    end
  end
endmodule

// File: doc/freq_mult_param.md
# freq_mult_param

Parametrised frequency multiplier: measures the period of a slow input square wave `InFreq` in `RefClk` cycles and synthesises `OutFreq` at `n` times that frequency. It supersedes the fixed 16-bit/3-bit multiplier with configurable widths, a sequential divider, overflow detection, a `locked` status, and an optional continuous-tracking mode that follows input drift without glitching the output. It sits between the board's reference clock domain and any logic consuming a derived clock-enable.

## Interface
- `CNT_W`, 16: width of the period counter, `period` and `shiftduration`.
- `N_W`, 3: width of multiplier input `n`.
- `TRACK`, 0: 0 = one-shot measurement per `adjust`; 1 = continuous re-measurement while running.
- `RefClk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `adjust`  in  1  start/restart a measurement; sampled every cycle.
- `InFreq`  in  1  asynchronous input square wave; 2-flop synchronised internally.
- `n`  in  N_W  multiplication factor; captured on `adjust`; 0 treated as 1.
- `OutFreq`  out  1  synthesised output, 50 % duty (integer half-period).
- `done`  out  1  one-cycle pulse when the first half-period is valid.
- `locked`  out  1  high while in RUN.
- `ovf`  out  1  sticky: period counter saturated; cleared by `adjust` or `rst`.
- `period`  out  CNT_W  last measured input period P, in RefClk cycles.
- `shiftduration`  out  CNT_W  active half-period H, in RefClk cycles.

## Operation
- States: IDLE, SYNC, MEASURE, DIVIDE, RUN.
- Rise detect: `InFreq` → 2 flops → edge flop; `rise` pulses one cycle per rising edge. Latency is constant, so P is exact.
- IDLE: `OutFreq`=0, `locked`=0. `adjust`=1 → SYNC. Capture `n` (0→1), clear `ovf`.
- SYNC: wait for `rise`. Clear the counter → MEASURE.
- MEASURE: counter increments each cycle. P = number of cycles between consecutive `rise` pulses (InFreq period of 40 RefClk → P=40). On `rise`, load `period` → DIVIDE.
- Counter reaching 2^CNT_W−1 without `rise`: set `ovf`, go to IDLE. This applies in SYNC, MEASURE and (TRACK=1) RUN.
- DIVIDE: restoring divider, H = floor(P / (2·n)), CNT_W iterations at one bit per cycle. If the result is 0, clamp H to 1. Load `shiftduration`, pulse `done` → RUN.
- RUN: half-period counter. `OutFreq` toggles each time H cycles elapse, giving a high time of H and a low time of H. `locked`=1.
- TRACK=0: RUN holds until `adjust` or `rst`.
- TRACK=1: measurement and divider run in the background. The new H and `period` are applied only on the cycle `OutFreq` toggles, so no truncated half-cycle occurs. `done` does not re-pulse. Background overflow → `ovf`, IDLE.
- `adjust` in any non-IDLE state restarts at SYNC: `OutFreq` forced 0, `locked` 0, `n` recaptured. Changes to `n` without `adjust` are ignored.
- `adjust` and `rise` in the same cycle: `adjust` wins.

## Timing
- Reset values: `OutFreq`=0, `done`=0, `locked`=0, `ovf`=0, `period`=0, `shiftduration`=0. State = IDLE; all counters 0.
- `adjust` sampled high at cycle k → state SYNC at k+1.
- `InFreq` edge → `rise` after 3 RefClk cycles.
- MEASURE→DIVIDE on the `rise` cycle. DIVIDE lasts CNT_W cycles; `done` is high in the first RUN cycle.
- In RUN, `OutFreq` is 0 on entry. The first toggle to 1 happens H cycles after entry.
- `rst` mid-operation returns every output to its reset value on the next edge.

## Test plan
- InFreq period 40, n=2, CNT_W=16 → `period`=40, `shiftduration`=10, one `done` pulse, `OutFreq` 10 high / 10 low, `locked`=1.
- InFreq period 7, n=4 → H=floor(7/8)=0 clamped to 1; `OutFreq` toggles every cycle. n=0 with period 40 → H=20.
- InFreq held low after `adjust`, CNT_W=8 → `ovf`=1 after 255 counted cycles, state IDLE, `OutFreq`=0. Next `adjust` clears `ovf`.
- TRACK=1, period changes 40→80 mid-RUN with n=2 → H changes 10→20 exactly at an `OutFreq` toggle. No pulse shorter than 10 cycles; `locked` stays 1.
- `adjust` reasserted during RUN with n changed to 5 → `OutFreq` drops to 0 next cycle, `locked`=0. After re-measure of period 40: H=4, new `done`.
- `rst` asserted during DIVIDE → all outputs zero next cycle. `done` never pulses until a fresh `adjust`.
